remote_key_dispatcher: RTL and testbench

REMOTE_KEY_DISPATCHER -- requirements
Module: remote_key_dispatcher

---
 rtl/remote_key_dispatcher_pkg.sv | 24 ++
 rtl/remote_key_dispatcher_if.sv | 36 +++
 rtl/remote_key_dispatcher_key_fifo.sv | 63 ++++++
 rtl/remote_key_dispatcher.sv | 144 ++++++++++++++
 tb/tb_remote_key_dispatcher.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_key_dispatcher_pkg.sv
// Shared definitions for the remote key dispatcher.
// Contents:
//   INVALID_KEY      decoder code meaning "no key"
//   NUM_MAX_DEFAULT  highest code routed to the numeric consumer
//   COUNT_W          width of the fifo_count output
//   dispatch_state_t dispatch FSM state encoding
//   is_numeric()     routing decision for a key code
package remote_key_dispatcher_pkg;

  localparam logic [7:0] INVALID_KEY     = 8'hFF;
  localparam logic [7:0] NUM_MAX_DEFAULT = 8'h09;
  localparam int         COUNT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NUM_OUT = 2'd1,
    ST_CMD_OUT = 2'd2
  } dispatch_state_t;

  function automatic logic is_numeric(input logic [7:0] key, input logic [7:0] num_max);
    return (key <= num_max);
  endfunction

endpackage

// File: rtl/remote_key_dispatcher_if.sv
// Bus between the key decoder / consumers and the dispatcher.
// Signals:
//   ready, remote_key      decoder level-valid and key code
//   num_valid/num_digit    numeric offer, num_ack accepts it
//   cmd_valid/cmd_code     command offer, cmd_ack accepts it
//   overflow, fifo_count   status
// Handshake: an offer is made by raising *_valid with its data; data is held
// stable while *_valid is high and the offer completes on the first rising
// clock edge where *_ack is also high. *_ack has no effect while the matching
// *_valid is low.
// Modports: slave = dispatcher side, master = decoder/consumer side.
interface remote_key_dispatcher_if;
  import remote_key_dispatcher_pkg::*;

  logic               ready;
  logic [7:0]         remote_key;
  logic               num_ack;
  logic               cmd_ack;
  logic               num_valid;
  logic [3:0]         num_digit;
  logic               cmd_valid;
  logic [7:0]         cmd_code;
  logic               overflow;
  logic [COUNT_W-1:0] fifo_count;

  modport slave (
    input  ready, remote_key, num_ack, cmd_ack,
    output num_valid, num_digit, cmd_valid, cmd_code, overflow, fifo_count
  );

  modport master (
    output ready, remote_key, num_ack, cmd_ack,
    input  num_valid, num_digit, cmd_valid, cmd_code, overflow, fifo_count
  );

endinterface

// File: rtl/remote_key_dispatcher_key_fifo.sv
// key_fifo: small synchronous FIFO holding accepted key codes.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, push_data  write request and data (written at the tail)
//   pop              read request (head advances)
//   head             current head entry (valid when !empty)
//   full, empty      occupancy flags
//   count            occupancy 0..DEPTH
// A push while full is honoured only when a pop happens in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/remote_key_dispatcher.sv
// remote_key_dispatcher: captures key presses from an IR decoder, filters
// invalid codes and auto-repeats, queues them and hands each key to either
// the numeric or the command consumer, in capture order.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          remote_key_dispatcher_if.slave (decoder + consumer handshakes)
//   dbg_state    current dispatch FSM state
// Parameters:
//   DEPTH    key FIFO entries (power of two, 2..16)
//   HOLDOFF  cycles during which a repeat of the last accepted key is dropped
//   NUM_MAX  highest key code routed to the numeric consumer
module remote_key_dispatcher
  import remote_key_dispatcher_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         HOLDOFF = 16,
  parameter logic [7:0] NUM_MAX = NUM_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  remote_key_dispatcher_if.slave   bus,
  output dispatch_state_t          dbg_state
);

  localparam int              HW           = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0]   HOLDOFF_LOAD = HW'(HOLDOFF);
  localparam int              FCW          = $clog2(DEPTH) + 1;

  // ---------------- capture filter ----------------
  logic          ready_d;
  logic [HW-1:0] holdoff_q;
  logic [7:0]    last_key_q;
  logic          overflow_q;
  logic          capture;
  logic          key_ok;
  logic          is_repeat;
  logic          candidate;
  logic          accept;
  logic          drop_full;

  // ---------------- FIFO / FSM ----------------
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_head;
  logic [FCW-1:0]  fifo_cnt;
  dispatch_state_t state_q, state_d;
  logic [3:0]      digit_q, digit_d;
  logic [7:0]      code_q, code_d;

  // ready is a level that may stay high for many cycles; only its rising
  // edge is a key press.
  assign capture   = bus.ready & ~ready_d;
  assign key_ok    = (bus.remote_key != INVALID_KEY);
  assign is_repeat = (bus.remote_key == last_key_q) && (holdoff_q != '0);
  assign candidate = capture & key_ok & ~is_repeat;
  // A full FIFO still takes the key when the dispatcher pops in the same cycle.
  assign accept    = candidate & (~fifo_full | fifo_pop);
  assign drop_full = candidate & fifo_full & ~fifo_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_d    <= 1'b0;
      holdoff_q  <= '0;
      last_key_q <= INVALID_KEY;
      overflow_q <= 1'b0;
    end else begin
      ready_d    <= bus.ready;
      overflow_q <= drop_full;
      // Only accepted keys restart the holdoff window; dropped repeats and
      // overflow drops leave it running down.
      if (accept) begin
        holdoff_q  <= HOLDOFF_LOAD;
        last_key_q <= bus.remote_key;
      end else if (holdoff_q != '0) begin
        holdoff_q  <= holdoff_q - HW'(1);
      end
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_key_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (bus.remote_key),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // ---------------- dispatch FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      digit_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      code_q  <= code_d;
    end
  end

  // The head is popped and its data registered in the same cycle, so the
  // offer appears one edge after the pop. Returning through IDLE after each
  // ack guarantees a gap cycle between offers.
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    code_d   = code_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_numeric(fifo_head, NUM_MAX)) begin
            state_d = ST_NUM_OUT;
            digit_d = fifo_head[3:0];
          end else begin
            state_d = ST_CMD_OUT;
            code_d  = fifo_head;
          end
        end
      end
      ST_NUM_OUT: if (bus.num_ack) state_d = ST_IDLE;
      ST_CMD_OUT: if (bus.cmd_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign bus.num_valid  = (state_q == ST_NUM_OUT);
  assign bus.cmd_valid  = (state_q == ST_CMD_OUT);
  assign bus.num_digit  = digit_q;
  assign bus.cmd_code   = code_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = COUNT_W'(fifo_cnt);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_remote_key_dispatcher.sv
// Testbench for remote_key_dispatcher: directed key sequences, a queue-based
// reference model checked every cycle, and hand-computed spot checks.
module tb_remote_key_dispatcher;
  import remote_key_dispatcher_pkg::*;

  localparam int         DEPTH   = 4;
  localparam int         HOLDOFF = 16;
  localparam logic [7:0] NUM_MAX = 8'h09;

  // ---------------- clock / reset ----------------
  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  dispatch_state_t dbg_state;

  always #5 clk = ~clk;

  remote_key_dispatcher_if bus();

  remote_key_dispatcher #(
    .DEPTH   (DEPTH),
    .HOLDOFF (HOLDOFF),
    .NUM_MAX (NUM_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic auto_ack    = 1'b0;
  logic man_num_ack = 1'b0;
  logic man_cmd_ack = 1'b0;

  assign bus.num_ack = auto_ack ? bus.num_valid : man_num_ack;
  assign bus.cmd_ack = auto_ack ? bus.cmd_valid : man_cmd_ack;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted keys waiting for dispatch, the key currently offered, and the
  // time of the last accepted key (a repeat within HOLDOFF cycles is dropped).
  logic [7:0] exp_q[$];
  int         m_offer;          // 0 nothing, 1 numeric, 2 command
  logic [3:0] m_digit;
  logic [7:0] m_code;
  logic       m_ovf;
  logic [7:0] m_last;
  int         m_last_t;
  int         cyc = 0;
  logic       m_ready_prev;
  bit         model_live = 0;
  bit         m_pop, m_cap, m_cand, m_acc;
  logic [7:0] m_k;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_offer      = 0;
      m_digit      = '0;
      m_code       = '0;
      m_ovf        = 1'b0;
      m_last       = 8'hFF;
      m_last_t     = -1000;
      m_ready_prev = 1'b0;
      model_live   = 1;
    end else begin
      m_pop  = (m_offer == 0) && (exp_q.size() > 0);
      m_cap  = bus.ready && !m_ready_prev;
      m_cand = m_cap && (bus.remote_key != 8'hFF) &&
               !((bus.remote_key == m_last) && ((cyc - m_last_t) <= HOLDOFF));
      m_acc  = m_cand && ((exp_q.size() < DEPTH) || m_pop);
      m_ovf  = m_cand && !m_acc;
      if (m_offer == 1 && bus.num_ack) m_offer = 0;
      if (m_offer == 2 && bus.cmd_ack) m_offer = 0;
      if (m_pop) begin
        m_k = exp_q.pop_front();
        if (m_k <= NUM_MAX) begin
          m_offer = 1;
          m_digit = m_k[3:0];
        end else begin
          m_offer = 2;
          m_code  = m_k;
        end
      end
      if (m_acc) begin
        exp_q.push_back(bus.remote_key);
        m_last   = bus.remote_key;
        m_last_t = cyc;
      end
      m_ready_prev = bus.ready;
    end
  end

  // Offer / overflow event counters, sampled before the edge updates the DUT.
  int   num_offers = 0;
  int   cmd_offers = 0;
  int   ovf_pulses = 0;
  logic prev_num = 1'b0;
  logic prev_cmd = 1'b0;

  always @(posedge clk) begin
    if (bus.num_valid === 1'b1 && prev_num !== 1'b1) num_offers++;
    if (bus.cmd_valid === 1'b1 && prev_cmd !== 1'b1) cmd_offers++;
    if (bus.overflow === 1'b1) ovf_pulses++;
    prev_num = bus.num_valid;
    prev_cmd = bus.cmd_valid;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("num_valid", 32'(bus.num_valid), 32'(m_offer == 1));
      check("cmd_valid", 32'(bus.cmd_valid), 32'(m_offer == 2));
      if (m_offer == 1) check("num_digit", 32'(bus.num_digit), 32'(m_digit));
      if (m_offer == 2) check("cmd_code", 32'(bus.cmd_code), 32'(m_code));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
      check("valid_exclusive", 32'(bus.num_valid & bus.cmd_valid), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] key, input int hold);
    bus.ready      = 1'b1;
    bus.remote_key = key;
    repeat (hold) @(negedge clk);
    bus.ready      = 1'b0;
  endtask

  task automatic ack_num();
    man_num_ack = 1'b1;
    @(negedge clk);
    man_num_ack = 1'b0;
  endtask

  task automatic ack_cmd();
    man_cmd_ack = 1'b1;
    @(negedge clk);
    man_cmd_ack = 1'b0;
  endtask

  task automatic wait_offer(input int kind, input int max_cycles);
    int n;
    n = 0;
    while (((kind == 1) ? bus.num_valid : bus.cmd_valid) !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check((kind == 1) ? "wait_num_offer" : "wait_cmd_offer",
          32'((kind == 1) ? bus.num_valid : bus.cmd_valid), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    bus.ready      = 1'b0;
    bus.remote_key = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_num_valid", 32'(bus.num_valid), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_num_digit", 32'(bus.num_digit), 32'd0);
    check("rst_cmd_code", 32'(bus.cmd_code), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Key 05 held three cycles: one capture, offer after the second edge.
    reset          = 1'b0;
    bus.ready      = 1'b1;
    bus.remote_key = 8'h05;
    @(negedge clk);
    check("lat_count_k", 32'(bus.fifo_count), 32'd1);
    check("lat_valid_k", 32'(bus.num_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k1", 32'(bus.num_valid), 32'd1);
    check("lat_digit", 32'(bus.num_digit), 32'h5);
    check("lat_count_k1", 32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    bus.ready = 1'b0;
    ack_num();
    check("num_drop_after_ack", 32'(bus.num_valid), 32'd0);
    idle(2);
    check("single_capture", 32'(bus.fifo_count), 32'd0);

    // Ack on the wrong channel is ignored.
    press(8'h20, 1);
    wait_offer(2, 5);
    man_num_ack = 1'b1;
    @(negedge clk);
    man_num_ack = 1'b0;
    check("wrong_chan_ack", 32'(bus.cmd_valid), 32'd1);
    ack_cmd();
    check("cmd_drop_after_ack", 32'(bus.cmd_valid), 32'd0);
    idle(2);

    // Holdoff: 16 accepted at c, repeat at c+10 dropped, repeat at c+20 accepted.
    base = cmd_offers;
    press(8'h16, 1);
    @(negedge clk);
    check("hold_first_valid", 32'(bus.cmd_valid), 32'd1);
    check("hold_first_code", 32'(bus.cmd_code), 32'h16);
    ack_cmd();
    check("hold_first_done", 32'(bus.cmd_valid), 32'd0);
    idle(7);
    press(8'h16, 1);
    idle(3);
    check("hold_repeat_dropped", 32'(bus.cmd_valid), 32'd0);
    check("hold_repeat_count", 32'(bus.fifo_count), 32'd0);
    idle(6);
    press(8'h16, 1);
    @(negedge clk);
    check("hold_second_valid", 32'(bus.cmd_valid), 32'd1);
    check("hold_second_code", 32'(bus.cmd_code), 32'h16);
    ack_cmd();
    idle(2);
    check("hold_offer_total", 32'(cmd_offers - base), 32'd2);

    // Holdoff boundary: repeat exactly HOLDOFF cycles later is still dropped.
    auto_ack = 1'b1;
    base = cmd_offers;
    press(8'h30, 1);
    idle(15);
    press(8'h30, 1);
    idle(1);
    press(8'h30, 1);
    idle(4);
    auto_ack = 1'b0;
    idle(1);
    check("hold_edge_offers", 32'(cmd_offers - base), 32'd2);

    // Ordering across channels with acks withheld.
    press(8'h01, 1);
    idle(1);
    press(8'h40, 1);
    idle(1);
    press(8'h02, 1);
    wait_offer(1, 10);
    check("order_1", 32'(bus.num_digit), 32'h1);
    check("order_1_cmd_low", 32'(bus.cmd_valid), 32'd0);
    ack_num();
    wait_offer(2, 10);
    check("order_2", 32'(bus.cmd_code), 32'h40);
    ack_cmd();
    wait_offer(1, 10);
    check("order_3", 32'(bus.num_digit), 32'h2);
    ack_num();
    idle(2);
    check("order_drained", 32'(bus.fifo_count), 32'd0);

    // Six distinct keys, no acks: one offered, four queued, sixth overflows.
    base = ovf_pulses;
    for (int i = 0; i < 6; i++) begin
      press(8'h81 + 8'(i), 1);
      idle(1);
    end
    idle(2);
    check("fill_count", 32'(bus.fifo_count), 32'd4);
    check("fill_offer", 32'(bus.cmd_code), 32'h81);
    check("fill_valid", 32'(bus.cmd_valid), 32'd1);
    check("fill_ovf_pulses", 32'(ovf_pulses - base), 32'd1);

    // Full FIFO with a pop in the same cycle takes the new key.
    man_cmd_ack = 1'b1;
    @(negedge clk);
    man_cmd_ack    = 1'b0;
    bus.ready      = 1'b1;
    bus.remote_key = 8'h87;
    @(negedge clk);
    bus.ready = 1'b0;
    check("full_pop_count", 32'(bus.fifo_count), 32'd4);
    check("full_pop_code", 32'(bus.cmd_code), 32'h82);
    check("full_pop_no_ovf", 32'(bus.overflow), 32'd0);
    ack_cmd();
    @(negedge clk);
    check("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    check("pre_rst_valid", 32'(bus.cmd_valid), 32'd1);
    check("pre_rst_code", 32'(bus.cmd_code), 32'h83);

    // Reset mid-offer clears everything, no ack needed.
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    check("mid_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("mid_rst_num_valid", 32'(bus.num_valid), 32'd0);
    check("mid_rst_cmd_code", 32'(bus.cmd_code), 32'd0);
    check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // ready already high when reset releases counts as a press.
    bus.ready      = 1'b1;
    bus.remote_key = 8'h07;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_capture", 32'(bus.fifo_count), 32'd1);
    @(negedge clk);
    check("rel_valid", 32'(bus.num_valid), 32'd1);
    check("rel_digit", 32'(bus.num_digit), 32'h7);
    bus.ready = 1'b0;
    ack_num();
    idle(2);

    // Invalid code is ignored.
    press(8'hFF, 2);
    idle(3);
    check("inv_count", 32'(bus.fifo_count), 32'd0);
    check("inv_num_valid", 32'(bus.num_valid), 32'd0);
    check("inv_cmd_valid", 32'(bus.cmd_valid), 32'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against any stall in the directed sequence.
  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
